reg_access_arbiter: RTL and testbench

Shares one DATA_WIDTH storage register between NUM_REQ requesters, each able to issue read or write accesses. It grants at most one access per cycle using two-class round-robin arbitration: writes have priority over reads, and a starvation counter bounds read latency. It sits between the processor's requesting units and the register it owns, and returns registered read data tagged with the requester ID.

---
 rtl/reg_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 35 +++
 rtl/reg_access_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_access_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register access arbiter.
package reg_arb_pkg;

  // Access class chosen for a cycle
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_WRITE = 2'd1,
    CLS_READ  = 2'd2
  } arb_class_e;

  // Legal parameter ranges
  localparam int unsigned DATA_WIDTH_MIN   = 8;
  localparam int unsigned DATA_WIDTH_MAX   = 32;
  localparam int unsigned NUM_REQ_MIN      = 2;
  localparam int unsigned NUM_REQ_MAX      = 8;
  localparam int unsigned STARVE_LIMIT_MIN = 1;
  localparam int unsigned STARVE_LIMIT_MAX = 15;

  // Width of an index that addresses n requesters (at least 1 bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of vec searching upward from ptr+1, with wrap.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  localparam int unsigned NU = N;

  logic [IW-1:0] pos;

  // Scan N positions starting after the pointer; first hit wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      pos = IW'((32'(ptr) + k) % NU);
      if (!found && vec[pos]) begin
        found    = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shared storage register with write-priority round-robin arbitration
// and a starvation bound on pending reads.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rvalid,
  output logic [$clog2(NUM_REQ)-1:0]    rid,
  output logic [DATA_WIDTH-1:0]         reg_q
);

  localparam int IW = idx_width(NUM_REQ);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [NUM_REQ-1:0]    w_vec;
  logic [NUM_REQ-1:0]    r_vec;
  logic [NUM_REQ-1:0]    cls_vec;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic [IW-1:0]         last_gnt;
  logic [3:0]            starve_cnt;
  logic                  force_read;
  logic                  wr_grant;
  logic                  rd_grant;
  arb_class_e            cls;
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  assign w_vec      = req & req_we;
  assign r_vec      = req & ~req_we;
  assign force_read = (starve_cnt == LIMIT);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Class selection: forced read, else writes, else reads
  always_comb begin
    cls     = CLS_NONE;
    cls_vec = '0;
    if (force_read && (|r_vec)) begin
      cls = CLS_READ;
    end else if (|w_vec) begin
      cls = CLS_WRITE;
    end else if (|r_vec) begin
      cls = CLS_READ;
    end
    case (cls)
      CLS_WRITE: cls_vec = w_vec;
      CLS_READ:  cls_vec = r_vec;
      default:   cls_vec = '0;
    endcase
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .vec   (cls_vec),
    .ptr   (last_gnt),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign gnt      = reset ? '0 : pick_gnt;
  assign wr_grant = pick_found && (cls == CLS_WRITE);
  assign rd_grant = pick_found && (cls == CLS_READ);

  // Shared round-robin pointer advances on every grant of either class
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= IW'(NUM_REQ - 1);
    end else if (pick_found) begin
      last_gnt <= pick_idx;
    end
  end

  // Storage register loads the granted writer's slice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q <= '0;
    end else if (wr_grant) begin
      reg_q <= wdata_arr[pick_idx];
    end
  end

  // Read return: capture pre-edge contents and tag with the reader
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rid    <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_grant;
      if (rd_grant) begin
        rdata <= reg_q;
        rid   <= pick_idx;
      end
    end
  end

  // Starvation counter: counts writes granted over pending reads, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!(|r_vec) || rd_grant) begin
      starve_cnt <= '0;
    end else if (wr_grant && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter with a read-return scoreboard.
module tb_reg_access_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [1:0]  rid;
  logic [7:0]  reg_q;

  int tests;
  int failed;
  int unsigned cyc;
  logic [7:0] model_q;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  id;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  reg_access_arbiter #(
    .DATA_WIDTH   (8),
    .NUM_REQ      (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rid       (rid),
    .reg_q     (reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-return monitor: every rvalid must match the scoreboard head for this cycle
  always @(posedge clk) begin
    #1;
    if (rvalid) begin
      tests++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        failed++;
        $display("FAIL rvalid_unexpected cyc=%0d rid=%0d rdata=%h", cyc, rid, rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || rid !== e.id) begin
          failed++;
          $display("FAIL read_return cyc=%0d got rid=%0d rdata=%h expected rid=%0d rdata=%h",
                   cyc, rid, rdata, e.id, e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
      tests++;
      failed++;
      e = sb.pop_front();
      $display("FAIL read_missing cyc=%0d got rvalid=0 expected rid=%0d rdata=%h", cyc, e.id, e.data);
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] we, input logic [31:0] wd);
    @(negedge clk);
    req       = r;
    req_we    = we;
    req_wdata = wd;
    #1;
  endtask

  // Expect a read return in the cycle after the upcoming edge
  task automatic push_read(input logic [1:0] id, input logic [7:0] data);
    exp_t x;
    x.cyc  = cyc + 1;
    x.id   = id;
    x.data = data;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req       = 4'b1111;
    req_we    = 4'b1111;
    req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0000) begin failed++; $display("FAIL reset_gnt got=%b expected=0000", gnt); end
    tests++;
    if (reg_q !== 8'h00 || rdata !== 8'h00 || rvalid !== 1'b0 || rid !== 2'd0) begin
      failed++;
      $display("FAIL reset_outputs reg_q=%h rdata=%h rvalid=%b rid=%0d expected all 0", reg_q, rdata, rvalid, rid);
    end
    req    = 4'b0000;
    req_we = 4'b0000;
    reset  = 1'b0;
    model_q = 8'h00;
  endtask

  task automatic test_write();
    drive(4'b0001, 4'b0001, 32'h0000_00A5);
    tests++;
    if (gnt !== 4'b0001) begin failed++; $display("FAIL write_gnt got=%b expected=0001", gnt); end
    model_q = 8'hA5;
    drive(4'b0000, 4'b0000, 32'h0);
    tests++;
    if (reg_q !== 8'hA5) begin failed++; $display("FAIL write_reg_q got=%h expected=a5", reg_q); end
    tests++;
    if (rvalid !== 1'b0) begin failed++; $display("FAIL write_no_rvalid got=%b expected=0", rvalid); end
  endtask

  task automatic test_read_rr();
    drive(4'b0110, 4'b0000, 32'h0);
    tests++;
    if (gnt !== 4'b0010) begin failed++; $display("FAIL read_rr_first got=%b expected=0010", gnt); end
    push_read(2'd1, model_q);
    drive(4'b0110, 4'b0000, 32'h0);
    tests++;
    if (gnt !== 4'b0100) begin failed++; $display("FAIL read_rr_second got=%b expected=0100", gnt); end
    push_read(2'd2, model_q);
    drive(4'b0000, 4'b0000, 32'h0);
  endtask

  task automatic test_write_priority();
    drive(4'b0011, 4'b0010, 32'h0000_3C77);
    tests++;
    if (gnt !== 4'b0010) begin failed++; $display("FAIL prio_write_first got=%b expected=0010", gnt); end
    model_q = 8'h3C;
    drive(4'b0001, 4'b0000, 32'h0);
    tests++;
    if (gnt !== 4'b0001) begin failed++; $display("FAIL prio_read_next got=%b expected=0001", gnt); end
    push_read(2'd0, model_q);
    drive(4'b0000, 4'b0000, 32'h0);
    tests++;
    if (reg_q !== 8'h3C) begin failed++; $display("FAIL prio_reg_q got=%h expected=3c", reg_q); end
  endtask

  task automatic test_starvation();
    logic [31:0] wd;
    logic [3:0]  exp;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        wd  = {4'(r + 1), 4'h3, 4'(r + 1), 4'h2, 4'(r + 1), 4'h1, 8'h00};
        exp = (k == 3) ? 4'b0001 : 4'(4'b0010 << k);
        drive(4'b1111, 4'b1110, wd);
        tests++;
        if (gnt !== exp) begin
          failed++;
          $display("FAIL starve_pattern round=%0d step=%0d got=%b expected=%b", r, k, gnt, exp);
        end
        if (k == 3) push_read(2'd0, model_q);
        else model_q = wd[8*(k+1) +: 8];
      end
    end
    drive(4'b0000, 4'b0000, 32'h0);
  endtask

  task automatic test_single_regrant();
    for (int unsigned k = 0; k < 2; k++) begin
      drive(4'b1000, 4'b1000, {8'(8'h60 + k), 24'h0});
      tests++;
      if (gnt !== 4'b1000) begin failed++; $display("FAIL single_regrant step=%0d got=%b expected=1000", k, gnt); end
      model_q = 8'(8'h60 + k);
    end
    drive(4'b0000, 4'b0000, 32'h0);
    tests++;
    if (reg_q !== model_q) begin failed++; $display("FAIL single_reg_q got=%h expected=%h", reg_q, model_q); end
  endtask

  task automatic test_wrap();
    logic [31:0] wd;
    logic [3:0]  exp;
    for (int unsigned k = 0; k < 5; k++) begin
      wd  = {8'(8'hA0 + k), 8'(8'hB0 + k), 8'(8'hC0 + k), 8'(8'hD0 + k)};
      exp = 4'(4'b0001 << (k % 4));
      drive(4'b1111, 4'b1111, wd);
      tests++;
      if (gnt !== exp) begin failed++; $display("FAIL wrap step=%0d got=%b expected=%b", k, gnt, exp); end
      model_q = wd[8*(k%4) +: 8];
    end
    drive(4'b0000, 4'b0000, 32'h0);
    tests++;
    if (reg_q !== model_q) begin failed++; $display("FAIL wrap_reg_q got=%h expected=%h", reg_q, model_q); end
  endtask

  task automatic test_reset_mid();
    drive(4'b0100, 4'b0000, 32'h0);
    tests++;
    if (gnt !== 4'b0100) begin failed++; $display("FAIL mid_read_gnt got=%b expected=0100", gnt); end
    push_read(2'd2, model_q);
    @(negedge clk);
    tests++;
    if (rvalid !== 1'b1) begin failed++; $display("FAIL mid_rvalid_before got=%b expected=1", rvalid); end
    reset     = 1'b1;
    req       = 4'b1000;
    req_we    = 4'b1000;
    req_wdata = 32'h7700_0000;
    #1;
    tests++;
    if (rvalid !== 1'b0 || rdata !== 8'h00 || reg_q !== 8'h00) begin
      failed++;
      $display("FAIL mid_reset_clear rvalid=%b rdata=%h reg_q=%h expected 0/00/00", rvalid, rdata, reg_q);
    end
    tests++;
    if (gnt !== 4'b0000) begin failed++; $display("FAIL mid_reset_gnt got=%b expected=0000", gnt); end
    @(negedge clk);
    tests++;
    if (reg_q !== 8'h00) begin failed++; $display("FAIL mid_reset_write_ignored got=%h expected=00", reg_q); end
    reset = 1'b0;
    #1;
    tests++;
    if (gnt !== 4'b1000) begin failed++; $display("FAIL mid_after_reset_gnt got=%b expected=1000", gnt); end
    model_q = 8'h77;
    drive(4'b0000, 4'b0000, 32'h0);
    tests++;
    if (reg_q !== 8'h77) begin failed++; $display("FAIL mid_after_reset_reg_q got=%h expected=77", reg_q); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    cyc    = 0;
    test_reset();
    test_write();
    test_read_rr();
    test_write_priority();
    test_starvation();
    test_single_regrant();
    test_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
